seg7_bcd_encoder: RTL and testbench
===================================

Name: seg7_bcd_encoder

Overview:
- Reverse path of the BCD-to-7-segment decoder: watches an active-low a..g segment bus (1 = segment off) and recovers the 4-bit code.
- Filters glitches by requiring N consecutive identical samples, then emits each new stable code once on a valid/ready handshake.
- Used by the digital-clock bench and self-check logic to read displayed digits back as BCD.

Parameters:
- STABLE_CNT, 4: consecutive identical samples needed to accept a pattern; legal range 2..255.
- CNT_W, 8: width of the stability counter; must satisfy 2^CNT_W > STABLE_CNT.

Ports:
- CP  in  1  clock; all state updates on the rising edge.
- CR_n  in  1  synchronous active-low reset, sampled on the CP rising edge.
- sample_en  in  1  sampling strobe; segment inputs are evaluated only in cycles where it is 1.
- a,b,c,d,e,f,g  in  1 each  active-low segment lines; pattern word is {a,b,c,d,e,f,g}, a is the MSB.
- bcd  out  4  recovered code.
- blank  out  1  accepted pattern was all-off (7'b111_1111).
- err  out  1  accepted pattern is not in the table.
- valid  out  1  result held and available.
- ready  in  1  consumer accepts the result when valid && ready.
- overrun  out  1  sticky: a new result arrived while the previous one was unaccepted.

Behaviour:
- Reset (CR_n=0 at an edge):
  - bcd=0, blank=1, err=0, valid=0, overrun=0.
  - prev=7'h7F, committed=7'h7F, cnt=0.
  - Synchronous only; reset mid-handshake drops the held result.
- Sampling (edge with sample_en=1), with pat = {a..g}:
  - pat==prev: cnt saturates-increments, stopping at STABLE_CNT-1.
  - pat!=prev: prev<=pat, cnt<=0.
  - sample_en=0: no change to prev or cnt.
- Acceptance event:
  - Occurs in a sample_en cycle where pat==prev, cnt==STABLE_CNT-2 (this is the STABLE_CNT-th identical sample), and pat!=committed.
  - On that edge: committed<=pat and the output register loads the decode.
  - Further identical samples do not re-emit; only a change followed by stability does.
  - A pattern that returns to the committed value after a glitch produces no event.
- Decode table, pattern -> bcd:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 0100000->6, 1001100->4, 0100100->5
  - 0001111->7, 0000000->8, 0000100->9, 0001101->10, 0011001->11, 0100011->12, 1001011->13
  - Aliases: 7/14 and 8/15 share patterns; the lower code wins. Lamp-test (all on) therefore decodes as 8.
  - 1111111: blank=1, bcd=0, err=0.
  - Any other pattern: err=1, bcd=4'hF, blank=0.
  - blank and err are cleared on every load unless the loaded pattern sets them.
- Handshake:
  - valid rises on the acceptance edge and stays high until an edge with ready=1.
  - bcd, blank and err are stable while valid=1.
  - Acceptance with valid=1 and ready=0 in the same cycle: the new result overwrites the held one, valid stays 1, overrun<=1.
  - Acceptance with valid=1 and ready=1 in the same cycle: the new result loads, valid stays 1, no overrun.
  - overrun clears only on reset.
- Latency: valid is seen in the cycle after the edge that registers the STABLE_CNT-th identical sample.

Optional Feature:
- Macro SEG7_DP_EN adds input dp (active-low decimal point) and output dp_out.
  - dp is part of the stability comparison, so an 8-bit pattern must be stable to accept.
  - dp_out is loaded alongside bcd, active-high (1 = point lit); reset value 0.
- Without the macro: no dp ports, 7-bit comparison only.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK=7'h7F and SEG_ALL_ON=7'h00;
  - localparam pattern constants SEG_D0..SEG_D13;
  - BCD_ERR=4'hF;
  - the pattern-to-code function seg7_decode, returning {err, blank, bcd}.
- One sub-module seg7_stable_filter: holds prev and cnt, and outputs pattern plus a one-cycle accept pulse. The top module keeps committed, the output register and the handshake.

Test Plan:
- STABLE_CNT=4, sample_en=1, ready=1, pattern 0010010 held 4 cycles -> valid rises once with bcd=2; holding 10 more cycles gives no further valid.
- Pattern 0100100 for 3 samples, 1 sample of 0000000, then 0100100 for 4 samples -> exactly one result, bcd=5, and no result for 8.
- ready=0; stable 1001111 then stable 0000110 -> valid stays 1 with bcd=3 and overrun=1; ready=1 -> valid falls next edge.
- Stable 1111110 -> err=1, bcd=F. Stable 1111111 -> blank=1, bcd=0, err=0. Stable 0000000 -> bcd=8.
- sample_en toggled every other cycle with stable 0000100 -> acceptance after 4 enabled samples (about 8 cycles), bcd=9. CR_n=0 while valid=1 -> all outputs reset next edge.
- SEG7_DP_EN defined: 0000001 with dp=0 held 4 samples -> bcd=0, dp_out=1; dp toggling every sample -> no acceptance.

Source files
------------

// File: rtl/seg7_pkg.sv
// Segment pattern constants and the pattern-to-BCD decode shared by the
// 7-segment read-back encoder.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_ALL_ON = 7'h00;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_D0  = 7'b0000001;
  localparam logic [6:0] SEG_D1  = 7'b1001111;
  localparam logic [6:0] SEG_D2  = 7'b0010010;
  localparam logic [6:0] SEG_D3  = 7'b0000110;
  localparam logic [6:0] SEG_D4  = 7'b1001100;
  localparam logic [6:0] SEG_D5  = 7'b0100100;
  localparam logic [6:0] SEG_D6  = 7'b0100000;
  localparam logic [6:0] SEG_D7  = 7'b0001111;
  localparam logic [6:0] SEG_D8  = 7'b0000000;
  localparam logic [6:0] SEG_D9  = 7'b0000100;
  localparam logic [6:0] SEG_D10 = 7'b0001101;
  localparam logic [6:0] SEG_D11 = 7'b0011001;
  localparam logic [6:0] SEG_D12 = 7'b0100011;
  localparam logic [6:0] SEG_D13 = 7'b1001011;

  localparam logic [3:0] BCD_ERR = 4'hF;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] bcd;
  } seg7_dec_t;

  // Codes 14/15 alias 7/8 on the display, so they are never produced.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
    seg7_dec_t r;
    r = '{err: 1'b0, blank: 1'b0, bcd: 4'd0};
    case (pat)
      SEG_D0:    r.bcd = 4'd0;
      SEG_D1:    r.bcd = 4'd1;
      SEG_D2:    r.bcd = 4'd2;
      SEG_D3:    r.bcd = 4'd3;
      SEG_D4:    r.bcd = 4'd4;
      SEG_D5:    r.bcd = 4'd5;
      SEG_D6:    r.bcd = 4'd6;
      SEG_D7:    r.bcd = 4'd7;
      SEG_D8:    r.bcd = 4'd8;
      SEG_D9:    r.bcd = 4'd9;
      SEG_D10:   r.bcd = 4'd10;
      SEG_D11:   r.bcd = 4'd11;
      SEG_D12:   r.bcd = 4'd12;
      SEG_D13:   r.bcd = 4'd13;
      SEG_BLANK: r.blank = 1'b1;
      default: begin
        r.err = 1'b1;
        r.bcd = BCD_ERR;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_bcd_encoder_if.sv
// Segment bus plus result handshake of the 7-segment read-back encoder.
// SEG7_DP_EN adds the decimal point input and its decoded output.
interface seg7_bcd_encoder_if;
  logic       sample_en;
  logic       a, b, c, d, e, f, g;
  logic       ready;
  logic [3:0] bcd;
  logic       blank;
  logic       err;
  logic       valid;
  logic       overrun;
`ifdef SEG7_DP_EN
  logic       dp;
  logic       dp_out;
`endif

  modport master (
    output sample_en, a, b, c, d, e, f, g, ready,
    input  bcd, blank, err, valid, overrun
`ifdef SEG7_DP_EN
    , output dp, input dp_out
`endif
  );

  modport slave (
    input  sample_en, a, b, c, d, e, f, g, ready,
    output bcd, blank, err, valid, overrun
`ifdef SEG7_DP_EN
    , input dp, output dp_out
`endif
  );
endinterface

// File: rtl/seg7_stable_filter.sv
// Glitch filter: flags the sample that completes STABLE_CNT identical
// consecutive enabled samples of the segment pattern.
module seg7_stable_filter #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8,
  parameter int PAT_W      = 7
) (
  input  logic             CP,
  input  logic             CR_n,
  input  logic             sample_en_i,
  input  logic [PAT_W-1:0] pat_i,
  output logic [PAT_W-1:0] pat_o,
  output logic             accept_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CNT - 2);

  logic [PAT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             same;

  assign same     = (pat_i == prev_q);
  assign pat_o    = pat_i;
  // Saturation at CNT_MAX makes this true exactly once per stable run.
  assign accept_o = sample_en_i && same && (cnt_q == CNT_ACC);

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (sample_en_i) begin
      if (same) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        prev_d = pat_i;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge CP) begin
    if (!CR_n) begin
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_bcd_encoder.sv
// 7-segment to BCD read-back encoder: filtered acceptance, one result per
// new stable pattern, valid/ready output with sticky overrun. Option: SEG7_DP_EN.
module seg7_bcd_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input logic                CP,
  input logic                CR_n,
  seg7_bcd_encoder_if.slave  bus
);

`ifdef SEG7_DP_EN
  localparam int PAT_W = 8;
  logic [PAT_W-1:0] pat_in;
  assign pat_in = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.dp};
`else
  localparam int PAT_W = 7;
  logic [PAT_W-1:0] pat_in;
  assign pat_in = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
`endif

  logic [PAT_W-1:0] pat;
  logic             accept;
  logic             load;
  seg7_dec_t        dec;

  logic [PAT_W-1:0] committed_q, committed_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             dp_q, dp_d;

  seg7_stable_filter #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W),
    .PAT_W      (PAT_W)
  ) u_filter (
    .CP          (CP),
    .CR_n        (CR_n),
    .sample_en_i (bus.sample_en),
    .pat_i       (pat_in),
    .pat_o       (pat),
    .accept_o    (accept)
  );

  // A pattern settling back onto the committed one is a glitch, not news.
  assign load = accept && (pat != committed_q);
  assign dec  = seg7_decode(pat[PAT_W-1 -: 7]);

  always_comb begin
    committed_d = committed_q;
    bcd_d       = bcd_q;
    blank_d     = blank_q;
    err_d       = err_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    dp_d        = dp_q;
    if (load) begin
      committed_d = pat;
      bcd_d       = dec.bcd;
      blank_d     = dec.blank;
      err_d       = dec.err;
      dp_d        = ~pat[0];
      valid_d     = 1'b1;
      if (valid_q && !bus.ready) overrun_d = 1'b1;
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CP) begin
    if (!CR_n) begin
      committed_q <= '1;
      bcd_q       <= 4'd0;
      blank_q     <= 1'b1;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      dp_q        <= 1'b0;
    end else begin
      committed_q <= committed_d;
      bcd_q       <= bcd_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.blank   = blank_q;
  assign bus.err     = err_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;
`ifdef SEG7_DP_EN
  assign bus.dp_out  = dp_q;
`else
  logic unused_dp;
  assign unused_dp = dp_q ^ dp_d;
`endif

endmodule

// File: tb/tb_seg7_bcd_encoder.sv
// Randomized + directed bench for seg7_bcd_encoder against a run-length
// reference model of the display read-back rules.
module tb_seg7_bcd_encoder;

  localparam int STABLE_CNT = 4;

  logic CP = 1'b0;
  logic CR_n;
  seg7_bcd_encoder_if bus ();

  seg7_bcd_encoder #(.STABLE_CNT(STABLE_CNT), .CNT_W(8)) dut (
    .CP   (CP),
    .CR_n (CR_n),
    .bus  (bus)
  );

  always #5 CP = ~CP;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Display table indexed by code; 14/15 look like 7/8.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001101; seg_tab[11] = 7'b0011001;
    seg_tab[12] = 7'b0100011; seg_tab[13] = 7'b1001011; seg_tab[14] = 7'b0001111;
    seg_tab[15] = 7'b0000000;
  end

  // Reference model state
  int         run;
  logic [7:0] m_last, m_comm;
  logic       m_valid, m_blank, m_err, m_ovr, m_dp;
  logic [3:0] m_bcd;
  int         rises;
  logic       last_valid;

  task automatic ref_decode(input logic [6:0] s, output logic [3:0] code,
                            output logic bl, output logic er);
    bit found = 0;
    code = 4'hF; bl = 0; er = 0;
    if (s == 7'h7F) begin
      code = 4'd0; bl = 1; found = 1;
    end else begin
      for (int i = 0; i < 16; i++)
        if (!found && seg_tab[i] == s) begin
          code = 4'(i); found = 1;
        end
    end
    if (!found) er = 1;
  endtask

  task automatic step(input bit rst_n, input bit sen, input bit rdy,
                      input logic [6:0] s, input bit dpv);
    logic [7:0] key;
    logic [3:0] code;
    logic       bl, er;
    CR_n = rst_n;
    bus.sample_en = sen;
    bus.ready = rdy;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = s;
`ifdef SEG7_DP_EN
    bus.dp = dpv;
    key = {s, dpv};
`else
    key = {s, 1'b1};
`endif
    if (!rst_n) begin
      run = 1; m_last = 8'hFF; m_comm = 8'hFF;
      m_valid = 0; m_bcd = 0; m_blank = 1; m_err = 0; m_ovr = 0; m_dp = 0;
    end else begin
      bit ev = 0;
      if (sen) begin
        if (key == m_last) run++;
        else begin
          m_last = key; run = 1;
        end
        if (run == STABLE_CNT && key != m_comm) ev = 1;
      end
      if (ev) begin
        if (m_valid && !rdy) m_ovr = 1;
        ref_decode(s, code, bl, er);
        m_comm = key; m_bcd = code; m_blank = bl; m_err = er;
        m_dp = ~key[0]; m_valid = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
    @(posedge CP);
    #1;
    chk("valid", bus.valid, m_valid);
    chk("bcd", bus.bcd, m_bcd);
    chk("blank", bus.blank, m_blank);
    chk("err", bus.err, m_err);
    chk("overrun", bus.overrun, m_ovr);
`ifdef SEG7_DP_EN
    chk("dp_out", bus.dp_out, m_dp);
`endif
    if (bus.valid && !last_valid) rises++;
    last_valid = bus.valid;
  endtask

  task automatic hold(input int n, input bit rdy, input logic [6:0] s);
    for (int i = 0; i < n; i++) step(1, 1, rdy, s, 1);
  endtask

  logic [6:0] pool [20];

  initial begin
    rises = 0; last_valid = 0;
    step(0, 0, 1, 7'h7F, 1);
    step(0, 0, 1, 7'h7F, 1);
    chk("rst_blank", bus.blank, 1'b1);

    // single clean acceptance, latency and no re-emit
    rises = 0;
    hold(3, 1, 7'b0010010);
    chk("t1_early", bus.valid, 1'b0);
    hold(1, 1, 7'b0010010);
    chk("t1_lat", bus.valid, 1'b1);
    chk("t1_bcd", bus.bcd, 4'd2);
    hold(10, 1, 7'b0010010);
    chk("t1_rises", rises, 1);

    // glitch inside a run restarts the count
    rises = 0;
    hold(3, 1, 7'b0100100);
    hold(1, 1, 7'b0000000);
    hold(4, 1, 7'b0100100);
    chk("t2_rises", rises, 1);
    chk("t2_bcd", bus.bcd, 4'd5);

    // overrun
    hold(4, 0, 7'b1001111);
    hold(4, 0, 7'b0000110);
    chk("t3_valid", bus.valid, 1'b1);
    chk("t3_bcd", bus.bcd, 4'd3);
    chk("t3_ovr", bus.overrun, 1'b1);
    hold(1, 1, 7'b0000110);
    chk("t3_drop", bus.valid, 1'b0);

    // error, blank, lamp test
    hold(4, 1, 7'b1111110);
    chk("t4_err", bus.err, 1'b1);
    chk("t4_errbcd", bus.bcd, 4'hF);
    hold(4, 1, 7'b1111111);
    chk("t4_blank", bus.blank, 1'b1);
    chk("t4_blerr", bus.err, 1'b0);
    hold(4, 1, 7'b0000000);
    chk("t4_lamp", bus.bcd, 4'd8);

    // gated sampling, then reset while valid
    for (int i = 0; i < 7; i++) step(1, (i % 2) == 0, 0, 7'b0000100, 1);
    chk("t5_valid", bus.valid, 1'b1);
    chk("t5_bcd", bus.bcd, 4'd9);
    step(0, 1, 0, 7'b0000100, 1);
    chk("t5_rst_valid", bus.valid, 1'b0);
    chk("t5_rst_ovr", bus.overrun, 1'b0);

`ifdef SEG7_DP_EN
    for (int i = 0; i < 4; i++) step(1, 1, 1, 7'b0000001, 0);
    chk("dp_bcd", bus.bcd, 4'd0);
    chk("dp_lit", bus.dp_out, 1'b1);
    rises = 0;
    for (int i = 0; i < 10; i++) step(1, 1, 1, 7'b0100000, i[0]);
    chk("dp_toggle_rises", rises, 0);
`endif

    // random segments drawn from table, blank and junk patterns
    for (int i = 0; i < 14; i++) pool[i] = seg_tab[i];
    pool[14] = 7'h7F; pool[15] = 7'b1111110; pool[16] = 7'b1010101;
    pool[17] = 7'b0110110; pool[18] = 7'b0000001; pool[19] = 7'b0000000;
    for (int r = 0; r < 250; r++) begin
      logic [6:0] s;
      bit dpv;
      int len;
      s = pool[$urandom_range(0, 19)];
      dpv = $urandom_range(0, 3) != 0;
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++)
        step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, s, dpv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
